// File: rtl/result_tx_serializer.sv
// result_tx_serializer: streams the N x N result matrix to the UART as two bytes per element, MSB first.
// Define RESULT_TX_CHECKSUM_EN to append an XOR checksum byte after the last element.
module result_tx_serializer #(
    parameter int MAX_N  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        matrix_size,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] FETCH   = 4'd1;
    localparam logic [3:0] LATCH   = 4'd2;
    localparam logic [3:0] SEND_HI = 4'd3;
    localparam logic [3:0] WAIT_HI = 4'd4;
    localparam logic [3:0] SEND_LO = 4'd5;
    localparam logic [3:0] WAIT_LO = 4'd6;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam logic [3:0] SEND_CK = 4'd7;
    localparam logic [3:0] WAIT_CK = 4'd8;
`endif
    localparam logic [3:0] DONE    = 4'd9;

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, total_q, total_d;
    logic [7:0]        lo_q, lo_d, tx_data_q, tx_data_d;
    logic              guard_q, guard_d;
    logic [3:0]        n;
    logic              ready, last;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0]        ck_q, ck_d;
`endif

    assign n     = (32'(matrix_size) > MAX_N) ? 4'(MAX_N) : matrix_size;
    assign ready = !guard_q && !tx_busy;
    assign last  = idx_q == total_q - ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        total_d   = total_q;
        lo_d      = lo_q;
        tx_data_d = tx_data_q;
        guard_d   = 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
        ck_d      = ck_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                idx_d   = '0;
                total_d = ADDR_W'(n) * ADDR_W'(n);
                state_d = (n == 4'd0) ? DONE : FETCH;
`ifdef RESULT_TX_CHECKSUM_EN
                ck_d    = '0;
`endif
            end
            FETCH: state_d = LATCH;
            // tx_data is loaded as the SEND state begins so it stays put until the next SEND
            LATCH: begin
                lo_d      = rd_data[7:0];
                tx_data_d = rd_data[DATA_W-1 -: 8];
                state_d   = SEND_HI;
`ifdef RESULT_TX_CHECKSUM_EN
                ck_d      = ck_q ^ rd_data[DATA_W-1 -: 8];
`endif
            end
            SEND_HI: begin
                guard_d = 1'b1;
                state_d = WAIT_HI;
            end
            WAIT_HI: if (ready) begin
                tx_data_d = lo_q;
                state_d   = SEND_LO;
`ifdef RESULT_TX_CHECKSUM_EN
                ck_d      = ck_q ^ lo_q;
`endif
            end
            SEND_LO: begin
                guard_d = 1'b1;
                state_d = WAIT_LO;
            end
            WAIT_LO: if (ready) begin
                if (last) begin
`ifdef RESULT_TX_CHECKSUM_EN
                    tx_data_d = ck_q;
                    state_d   = SEND_CK;
`else
                    state_d   = DONE;
`endif
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = FETCH;
                end
            end
`ifdef RESULT_TX_CHECKSUM_EN
            SEND_CK: begin
                guard_d = 1'b1;
                state_d = WAIT_CK;
            end
            WAIT_CK: state_d = ready ? DONE : WAIT_CK;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            total_q   <= '0;
            lo_q      <= '0;
            tx_data_q <= '0;
            guard_q   <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
            ck_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            total_q   <= total_d;
            lo_q      <= lo_d;
            tx_data_q <= tx_data_d;
            guard_q   <= guard_d;
`ifdef RESULT_TX_CHECKSUM_EN
            ck_q      <= ck_d;
`endif
        end
    end

    assign rd_en    = state_q == FETCH;
    assign rd_addr  = idx_q;
    assign tx_data  = tx_data_q;
`ifdef RESULT_TX_CHECKSUM_EN
    assign tx_start = (state_q == SEND_HI) || (state_q == SEND_LO) || (state_q == SEND_CK);
`else
    assign tx_start = (state_q == SEND_HI) || (state_q == SEND_LO);
`endif
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
endmodule
